// File: rtl/mul_share_arb.sv
// Round-robin arbiter/sequencer sharing one START/READY multiplier among NREQ requesters.
// Optional zero-operand bypass: define MUL_SHARE_ZERO_BYPASS_EN.
module mul_share_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    output logic [NREQ-1:0]   rsp_valid_o,
    input  logic [NREQ-1:0]   rsp_ready_i,
    output logic [2*W-1:0]    rsp_p_o,
    output logic              rsp_err_o,
    output logic              mul_start_o,
    output logic [W-1:0]      mul_a_o,
    output logic [W-1:0]      mul_b_o,
    input  logic              mul_ready_i,
    input  logic [2*W-1:0]    mul_p_i,
    output logic              busy_o
);

    localparam int unsigned GW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [2*W-1:0]  p_q, p_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;

    logic            arb_hit;
    logic [GW-1:0]   arb_idx;
    logic [W-1:0]    a_sel, b_sel;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        int unsigned idx;
        logic [GW-1:0] cand;
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = GW'(idx);
            if (!arb_hit && req_valid_i[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    assign a_sel = req_a_i[arb_idx*W +: W];
    assign b_sel = req_b_i[arb_idx*W +: W];

    // Accept strobe is combinational: the handshake completes in the IDLE cycle.
    assign req_ready_o = (state_q == IDLE && arb_hit) ? (NREQ'(1) << arb_idx) : '0;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        start_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    grant_d = arb_idx;
                    a_d     = a_sel;
                    b_d     = b_sel;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
                    if (a_sel == '0 || b_sel == '0) begin
                        state_d     = RESP;
                        p_d         = '0;
                        err_d       = 1'b0;
                        rsp_valid_d = NREQ'(1) << arb_idx;
                    end else begin
                        state_d = START;
                        start_d = 1'b1;
                    end
`else
                    state_d = START;
                    start_d = 1'b1;
`endif
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // First WAIT cycle (cnt_q == 0) may still see READY from the previous job.
                if (cnt_q != '0 && mul_ready_i) begin
                    p_d         = mul_p_i;
                    err_d       = 1'b0;
                    state_d     = RESP;
                    rsp_valid_d = NREQ'(1) << grant_q;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    p_d         = '0;
                    err_d       = 1'b1;
                    state_d     = RESP;
                    rsp_valid_d = NREQ'(1) << grant_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i[grant_q]) begin
                    last_d      = grant_q;
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= GW'(NREQ - 1);
            grant_q     <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_p_o     = p_q;
    assign rsp_err_o   = err_q;
    assign mul_start_o = start_q;
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: transaction-level model of arbitration, products and
// errors, plus a behavioural START/READY multiplier with selectable behaviour.
module tb_mul_share_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ*W-1:0] req_a_i, req_b_i;
    logic [NREQ-1:0]   rsp_valid_o;
    logic [NREQ-1:0]   rsp_ready_i;
    logic [2*W-1:0]    rsp_p_o;
    logic              rsp_err_o;
    logic              mul_start_o;
    logic [W-1:0]      mul_a_o, mul_b_o;
    logic              mul_ready_i;
    logic [2*W-1:0]    mul_p_i;
    logic              busy_o;

    always #5 clk = ~clk;

    mul_share_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_p_o(rsp_p_o), .rsp_err_o(rsp_err_o),
        .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_ready_i(mul_ready_i), .mul_p_i(mul_p_i), .busy_o(busy_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Multiplier model: 0 = READY in the 5th cycle counting START, held until next START;
    // 1 = READY stuck high; 2 = never READY.
    int           mul_mode = 0;
    logic         m_ready, m_run;
    logic [3:0]   m_cnt;
    logic [W-1:0] m_a, m_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b0; m_run <= 1'b0; m_cnt <= 4'd0; m_a <= '0; m_b <= '0;
        end else if (mul_start_o) begin
            m_ready <= 1'b0; m_run <= 1'b1; m_cnt <= 4'd3; m_a <= mul_a_o; m_b <= mul_b_o;
        end else if (m_run) begin
            if (m_cnt == 4'd1) begin
                m_ready <= 1'b1;
                m_run   <= 1'b0;
            end
            m_cnt <= m_cnt - 4'd1;
        end
    end

    assign mul_ready_i = (mul_mode == 1) ? 1'b1 : (mul_mode == 2) ? 1'b0 : m_ready;
    assign mul_p_i = (mul_mode == 1) ? 8'(8'(mul_a_o) * 8'(mul_b_o)) :
                     (m_ready ? 8'(8'(m_a) * 8'(m_b)) : 8'hA5);

    // Transaction model state
    int  cyc = 0;
    bit  job_open = 1'b0;
    int  model_last = NREQ - 1;
    int  job_g, job_a, job_b, exp_p, exp_err, exp_starts, starts, acc_cyc;
    bit  rsp_seen;
    int  last_lat, last_p, last_err;
    int  grant_log[$];
    int  p_log[$];
    int  lat_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every cycle, DUT outputs against the transaction model.
    always @(negedge clk) begin
        int eg;
        if (!rst_n) begin
            job_open   = 1'b0;
            model_last = NREQ - 1;
        end else begin
            chk_eq("busy", int'(busy_o), int'(job_open));
            if (req_ready_o != '0) begin
                eg = -1;
                for (int k = 1; k <= int'(NREQ); k++) begin
                    int idx;
                    idx = (model_last + k) % NREQ;
                    if (eg < 0 && req_valid_i[idx]) eg = idx;
                end
                chk_eq("accept_while_busy", int'(job_open), 0);
                chk_eq("req_ready_onehot", int'(req_ready_o), (eg < 0) ? 0 : (1 << eg));
                job_open   = 1'b1;
                job_g      = eg;
                job_a      = int'(req_a_i[eg*W +: W]);
                job_b      = int'(req_b_i[eg*W +: W]);
                exp_p      = (mul_mode == 2) ? 0 : job_a * job_b;
                exp_err    = (mul_mode == 2) ? 1 : 0;
                exp_starts = 1;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
                if (job_a == 0 || job_b == 0) begin
                    exp_p = 0; exp_err = 0; exp_starts = 0;
                end
`endif
                starts   = 0;
                acc_cyc  = cyc;
                rsp_seen = 1'b0;
                grant_log.push_back(eg);
            end
            if (mul_start_o) begin
                chk_eq("start_without_job", int'(job_open), 1);
                chk_eq("mul_a", int'(mul_a_o), job_a);
                chk_eq("mul_b", int'(mul_b_o), job_b);
                starts++;
            end
            if (rsp_valid_o != '0) begin
                chk_eq("rsp_without_job", int'(job_open), 1);
                chk_eq("rsp_valid", int'(rsp_valid_o), 1 << job_g);
                chk_eq("rsp_p", int'(rsp_p_o), exp_p);
                chk_eq("rsp_err", int'(rsp_err_o), exp_err);
                if (!rsp_seen) begin
                    rsp_seen = 1'b1;
                    last_lat = cyc - acc_cyc;
                    lat_log.push_back(last_lat);
                end
                if (job_open && rsp_ready_i[job_g]) begin
                    chk_eq("start_count", starts, exp_starts);
                    last_p     = int'(rsp_p_o);
                    last_err   = int'(rsp_err_o);
                    p_log.push_back(last_p);
                    model_last = job_g;
                    job_open   = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        logic [NREQ-1:0] rr;
        @(negedge clk);
        rr = req_ready_o;
        @(posedge clk);
        #1;
        req_valid_i = req_valid_i & ~rr;
    endtask

    task automatic post(input int i, input int a, input int b);
        req_a_i[i*W +: W] = W'(a);
        req_b_i[i*W +: W] = W'(b);
        req_valid_i[i]    = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        tick();
        while ((req_valid_i != '0 || busy_o || job_open) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk_eq({tag, "_drain_timeout"}, n, 0);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (rsp_valid_o == '0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk_eq({tag, "_rsp_timeout"}, n, 0);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        p_log.delete();
        lat_log.delete();
    endtask

    task automatic chk_log(input string tag, input int n,
                           input int g0, input int g1, input int g2, input int g3,
                           input int p0, input int p1, input int p2, input int p3);
        int ge[4];
        int pe[4];
        ge = '{g0, g1, g2, g3};
        pe = '{p0, p1, p2, p3};
        chk_eq({tag, "_grants"}, grant_log.size(), n);
        chk_eq({tag, "_rsps"}, p_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < grant_log.size()) chk_eq({tag, "_grant_order"}, grant_log[i], ge[i]);
            if (i < p_log.size())     chk_eq({tag, "_product"}, p_log[i], pe[i]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        rsp_ready_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_rsp_valid", int'(rsp_valid_o), 0);
        chk_eq("reset_busy", int'(busy_o), 0);
        chk_eq("reset_mul_start", int'(mul_start_o), 0);
        chk_eq("reset_rsp_p", int'(rsp_p_o), 0);
        rst_n       = 1'b1;
        rsp_ready_i = '1;
        tick();

        // Single job: 7*9, 5-cycle multiplier
        clear_logs();
        post(0, 7, 9);
        drain("single");
        chk_log("single", 1, 0, 0, 0, 0, 63, 0, 0, 0);
        chk_eq("single_latency", last_lat, 6);
        chk_eq("single_p_hex", last_p, 'h3F);
        chk_eq("single_busy_after", int'(busy_o), 0);

        // All four at once from a fresh reset
        do_reset();
        clear_logs();
        post(0, 1, 2); post(1, 3, 4); post(2, 5, 6); post(3, 15, 15);
        drain("all4");
        chk_log("all4", 4, 0, 1, 2, 3, 2, 12, 30, 225);

        // Back-pressure: only non-granted rsp_ready bits high
        clear_logs();
        rsp_ready_i = 4'b1110;
        post(0, 2, 3); post(1, 4, 4);
        wait_rsp("bp");
        repeat (10) tick();
        chk_eq("bp_hold_valid", int'(rsp_valid_o), 1);
        chk_eq("bp_hold_p", int'(rsp_p_o), 6);
        chk_eq("bp_req1_waiting", int'(req_valid_i[1]), 1);
        rsp_ready_i = '1;
        drain("bp");
        chk_log("bp", 2, 0, 1, 0, 0, 6, 16, 0, 0);

        // Stale READY held high through START
        clear_logs();
        mul_mode = 1;
        post(2, 5, 5);
        drain("stale");
        mul_mode = 0;
        chk_log("stale", 1, 2, 0, 0, 0, 25, 0, 0, 0);
        chk_eq("stale_latency", last_lat, 4);

        // Hung multiplier, then normal service
        clear_logs();
        mul_mode = 2;
        post(3, 6, 7);
        drain("hung");
        chk_eq("hung_latency", last_lat, 17);
        chk_eq("hung_err", last_err, 1);
        chk_eq("hung_p", last_p, 0);
        mul_mode = 0;
        post(0, 1, 1);
        drain("after_hung");
        chk_eq("after_hung_err", last_err, 0);
        chk_log("hung", 2, 3, 0, 0, 0, 0, 1, 0, 0);

        // Reset in the middle of WAIT
        post(2, 3, 3);
        while (req_valid_i[2]) tick();
        repeat (3) tick();
        chk_eq("pre_reset_busy", int'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_reset_busy", int'(busy_o), 0);
        chk_eq("mid_reset_mul_a", int'(mul_a_o), 0);
        chk_eq("mid_reset_mul_b", int'(mul_b_o), 0);
        chk_eq("mid_reset_rsp_valid", int'(rsp_valid_o), 0);
        chk_eq("mid_reset_req_ready", int'(req_ready_o), 0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_logs();
        tick();
        post(0, 0, 5); post(1, 2, 2);
        drain("post_reset");
        chk_log("post_reset", 2, 0, 1, 0, 0, 0, 4, 0, 0);
        if (lat_log.size() > 0) begin
`ifdef MUL_SHARE_ZERO_BYPASS_EN
            chk_eq("zero_latency", lat_log[0], 1);
`else
            chk_eq("zero_latency", lat_log[0], 6);
`endif
        end else begin
            chk_eq("zero_latency_missing", lat_log.size(), 2);
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
